// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the write-back buffer entry type.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;

  typedef struct packed {
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending write-back entries; exposes per-slot dest/valid for
// hazard compare and the entry that will sit at the head after this edge.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  wb_entry_t                    push_entry,
  input  logic                         pop,
  output wb_entry_t                    head_next,
  output logic [CNT_W-1:0]             count,
  output logic [CNT_W-1:0]             count_next,
  output logic                         empty,
  output logic [DEPTH-1:0]             entry_valid,
  output logic [DEPTH-1:0][REG_AW-1:0] entry_dest
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] remaining;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign count_next = count + CNT_W'(do_push) - CNT_W'(do_pop);
  assign rd_ptr_nxt = rd_ptr + PTR_W'(do_pop);
  assign remaining  = count - CNT_W'(do_pop);

  // When nothing survives the pop, the new head is the entry arriving this cycle.
  assign head_next = (remaining == '0) ? push_entry : mem[rd_ptr_nxt];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_dest[i]  = mem[i].dest;
      entry_valid[i] = ({1'b0, PTR_W'(PTR_W'(i) - rd_ptr)} < count);
    end
  end

  // NOTE: storage is not reset; every read of it is qualified by count/valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr_nxt;
      count  <= count_next;
    end
  end

endmodule

// File: rtl/result_writeback.sv
// Write-back stage: buffers ALU results and commits them to the register bank
// in arrival order, flagging read-after-write hazards to operand fetch.
module result_writeback
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [DATA_W-1:0] res_data,
  input  logic [REG_AW-1:0] res_dest,
  output logic              rf_wr_en,
  output logic [REG_AW-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  input  logic              rf_wr_ack,
  input  logic [REG_AW-1:0] rd_addr_a,
  input  logic [REG_AW-1:0] rd_addr_b,
  output logic              hazard,
  output logic [CNT_W-1:0]  pending
);

  typedef enum logic {
    ST_IDLE,
    ST_WRITE
  } state_t;

  state_t                       state;
  wb_entry_t                    push_entry;
  wb_entry_t                    head_next;
  logic [CNT_W-1:0]             count;
  logic [CNT_W-1:0]             count_next;
  logic                         empty;
  logic [DEPTH-1:0]             entry_valid;
  logic [DEPTH-1:0][REG_AW-1:0] entry_dest;
  logic                         push;
  logic                         pop;

  assign push_entry = '{dest: res_dest, data: res_data};
  assign push       = res_valid && res_ready;
  assign pop        = (state == ST_WRITE) && rf_wr_ack && !empty;
  assign pending    = count;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_next  (head_next),
    .count      (count),
    .count_next (count_next),
    .empty      (empty),
    .entry_valid(entry_valid),
    .entry_dest (entry_dest)
  );

  // NOTE: give every always_comb output a default first so no latch is inferred.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_dest[i] == rd_addr_a || entry_dest[i] == rd_addr_b))
        hazard = 1'b1;
    end
  end

  // The write port always presents the FIFO head; it advances only on ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      res_ready  <= 1'b0;
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
    end else begin
      res_ready <= (count_next < CNT_W'(DEPTH));
      case (state)
        ST_IDLE: begin
          if (count_next != '0) begin
            state      <= ST_WRITE;
            rf_wr_en   <= 1'b1;
            rf_wr_addr <= head_next.dest;
            rf_wr_data <= head_next.data;
          end
        end
        ST_WRITE: begin
          if (pop) begin
            if (count_next != '0) begin
              rf_wr_addr <= head_next.dest;
              rf_wr_data <= head_next.data;
            end else begin
              state    <= ST_IDLE;
              rf_wr_en <= 1'b0;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          rf_wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_writeback.sv
// Self-checking bench: a queue model of pending results is compared with the DUT
// every cycle, plus directed sequences with hand-computed expectations.
module tb_result_writeback;
  import cpu_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              res_valid = 1'b0;
  logic              res_ready;
  logic [DATA_W-1:0] res_data = '0;
  logic [REG_AW-1:0] res_dest = '0;
  logic              rf_wr_en;
  logic [REG_AW-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic              rf_wr_ack = 1'b0;
  logic [REG_AW-1:0] rd_addr_a = '0;
  logic [REG_AW-1:0] rd_addr_b = '0;
  logic              hazard;
  logic [CNT_W-1:0]  pending;

  result_writeback #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_dest  (res_dest),
    .rf_wr_en  (rf_wr_en),
    .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data),
    .rf_wr_ack (rf_wr_ack),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .hazard    (hazard),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] data;
  } ent_t;

  int                checks = 0;
  int                errors = 0;
  ent_t              q[$];
  bit                m_ready = 1'b0;
  bit                cmp_en = 1'b0;
  logic [DATA_W-1:0] m_bank [8];
  logic [DATA_W-1:0] dut_bank [8];
  int                wr_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_hazard();
    foreach (q[i]) if (q[i].dest == rd_addr_a || q[i].dest == rd_addr_b) return 1'b1;
    return 1'b0;
  endfunction

  // Ack retires the oldest pending result; a push is taken only if there was room before the edge.
  task automatic model_update();
    bit take;
    take = res_valid && m_ready;
    if (rf_wr_ack && q.size() > 0) begin
      m_bank[q[0].dest] = q[0].data;
      void'(q.pop_front());
    end
    if (take) q.push_back('{dest: res_dest, data: res_data});
    m_ready = (q.size() < DEPTH);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_ready = 1'b0;
  endtask

  always @(posedge clk) begin
    if (rst_n && rf_wr_en && rf_wr_ack) begin
      dut_bank[rf_wr_addr] <= rf_wr_data;
      wr_count <= wr_count + 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_res_ready", res_ready, m_ready);
      check("cmp_wr_en", rf_wr_en, q.size() > 0);
      if (q.size() > 0) begin
        check("cmp_wr_addr", rf_wr_addr, q[0].dest);
        check("cmp_wr_data", rf_wr_data, q[0].data);
      end
      check("cmp_pending", pending, q.size());
      check("cmp_hazard", hazard, model_hazard());
    end
  end

  task automatic push_one(input logic [REG_AW-1:0] d, input logic [DATA_W-1:0] v);
    res_valid = 1'b1;
    res_dest  = d;
    res_data  = v;
    tick();
    res_valid = 1'b0;
  endtask

  initial begin
    int writes_before;
    #1 cmp_en = 1'b1;

    // Reset then idle
    tick(); tick();
    @(negedge clk);
    check("rst_ready", res_ready, 0);
    check("rst_wr_en", rf_wr_en, 0);
    check("rst_addr", rf_wr_addr, 0);
    check("rst_data", rf_wr_data, 0);
    check("rst_pending", pending, 0);
    check("rst_hazard", hazard, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready_low", res_ready, 0);
    tick();
    @(negedge clk);
    check("rel_ready_high", res_ready, 1);

    // Single result with ack held high
    rf_wr_ack = 1'b1;
    push_one(3'd3, 16'h1234);
    @(negedge clk);
    check("single_en", rf_wr_en, 1);
    check("single_addr", rf_wr_addr, 3);
    check("single_data", rf_wr_data, 16'h1234);
    tick();
    @(negedge clk);
    check("single_en_off", rf_wr_en, 0);
    check("single_pending", pending, 0);

    // Ack stall
    rf_wr_ack = 1'b0;
    rd_addr_a = 3'd0;
    rd_addr_b = 3'd5;
    push_one(3'd5, 16'hBEEF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_en", rf_wr_en, 1);
      check("stall_addr", rf_wr_addr, 5);
      check("stall_data", rf_wr_data, 16'hBEEF);
      check("stall_hazard", hazard, 1);
      tick();
    end
    rf_wr_ack = 1'b1;
    tick();
    rf_wr_ack = 1'b0;
    @(negedge clk);
    check("stall_hazard_clr", hazard, 0);
    check("stall_en_off", rf_wr_en, 0);

    // Full buffer and backpressure
    push_one(3'd1, 16'hA001);
    push_one(3'd2, 16'hA002);
    res_valid = 1'b1; res_dest = 3'd4; res_data = 16'hA004;
    tick();
    @(negedge clk);
    check("full_ready", res_ready, 0);
    check("full_pending", pending, 2);
    rf_wr_ack = 1'b1;
    tick();
    rf_wr_ack = 1'b0;
    @(negedge clk);
    check("full_ready_back", res_ready, 1);
    check("full_pending_pop", pending, 1);
    tick();
    res_valid = 1'b0;
    @(negedge clk);
    check("full_third_in", pending, 2);
    rf_wr_ack = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("full_drained", pending, 0);
    check("full_last_write", dut_bank[4], 16'hA004);

    // Ordering of two writes to reg0
    push_one(3'd0, 16'h0001);
    @(negedge clk);
    check("order_first", rf_wr_data, 16'h0001);
    res_valid = 1'b1; res_dest = 3'd0; res_data = 16'h0002;
    tick();
    res_valid = 1'b0;
    @(negedge clk);
    check("order_b2b_en", rf_wr_en, 1);
    check("order_second", rf_wr_data, 16'h0002);
    tick();
    @(negedge clk);
    check("order_bank_dut", dut_bank[0], 16'h0002);
    check("order_bank_model", m_bank[0], 16'h0002);

    // Reset mid-operation
    rf_wr_ack = 1'b0;
    push_one(3'd6, 16'h0066);
    push_one(3'd7, 16'h0077);
    @(negedge clk);
    check("mid_pending", pending, 2);
    check("mid_en", rf_wr_en, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_en", rf_wr_en, 0);
    check("mid_rst_pending", pending, 0);
    check("mid_rst_hazard", hazard, 0);
    tick();
    rst_n = 1'b1;
    rf_wr_ack = 1'b1;
    writes_before = wr_count;
    repeat (8) tick();
    check("mid_no_writes", wr_count, writes_before);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      res_valid = ($urandom_range(0, 3) != 0);
      res_dest  = REG_AW'($urandom_range(0, 7));
      res_data  = DATA_W'($urandom);
      rf_wr_ack = ($urandom_range(0, 2) != 0);
      rd_addr_a = REG_AW'($urandom_range(0, 7));
      rd_addr_b = REG_AW'($urandom_range(0, 7));
      tick();
    end
    res_valid = 1'b0;
    rf_wr_ack = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    for (int r = 0; r < 8; r++) check("bank_final", dut_bank[r], m_bank[r]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
